// File: rtl/add_pkg.sv
// Shared definitions for the serial-arithmetic controllers: default operand
// width and the controller state encoding.
package add_pkg;

  localparam int unsigned ADD_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_e;

endpackage

// File: rtl/add_serial_ctrl_if.sv
// Request/result bundle of the bit-serial adder controller.
interface add_serial_ctrl_if
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/add_serial_ctrl_add_full.sv
// Single-bit full adder; the only arithmetic element on the serial sum path.
module add_full (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/add_serial_ctrl.sv
// Bit-serial adder controller: {cout,sum} = a + b + cin, one bit per clock,
// LSB first, through a single full adder.
module add_serial_ctrl
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  add_serial_ctrl_if.slave bus
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  add_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_shift;

  add_full u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .sum_o (fa_sum),
    .cout_o(fa_cout)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_shift = WIDTH'({fa_sum, res_q} >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        res_d   = res_shift;
        // Counter holds at LAST on the final bit instead of wrapping.
        if (cnt_q == LAST) begin
          sum_d   = res_shift;
          cout_d  = fa_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Self-checking bench for add_serial_ctrl at WIDTH 8, 2 and 32 against an
// integer a+b+cin reference.
module tb_add_serial_ctrl;

  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_serial_ctrl_if #(.WIDTH(8))  bus8 ();
  add_serial_ctrl_if #(.WIDTH(2))  bus2 ();
  add_serial_ctrl_if #(.WIDTH(32)) bus32 ();

  add_serial_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  add_serial_ctrl #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));
  add_serial_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  int checks = 0;
  int errors = 0;
  logic [7:0] last8 = '0;

  function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic c);
    return a + b + 64'(c);
  endfunction

  // Starts one addition on the WIDTH=8 instance (caller sits at a negedge)
  // and observes `window` cycles; k=0 is the cycle right after the accepting edge.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input bit hold, input int window,
                      output int first_done, output int n_done, output int busy_n,
                      output logic [7:0] s_o, output logic c_o, output bit stable);
    first_done = -1; n_done = 0; busy_n = 0; s_o = '0; c_o = 1'b0; stable = 1'b1;
    bus8.a = av; bus8.b = bv; bus8.cin = cv; bus8.start = 1'b1;
    @(negedge clk);
    if (hold) begin
      bus8.a = 8'h11; bus8.b = 8'h22;
    end else begin
      bus8.start = 1'b0;
    end
    for (int k = 0; k < window; k++) begin
      if (hold && k == W8) bus8.start = 1'b0;
      if (bus8.done === 1'b1) begin
        n_done++;
        if (first_done < 0) begin
          first_done = k; s_o = bus8.sum; c_o = bus8.cout;
        end
      end
      if (bus8.busy === 1'b1) busy_n++;
      if (first_done < 0 && bus8.sum !== last8) stable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;
    bus2.start = 1'b0;  bus2.a = '0;  bus2.b = '0;  bus2.cin = 1'b0;
    bus32.start = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h expected all 0",
               bus8.busy, bus8.done, bus8.cout, bus8.sum);
    end
    checks++;
    if ({bus32.busy, bus32.done, bus32.cout, bus32.sum, bus2.busy, bus2.sum} !== 38'h0) begin
      errors++;
      $display("FAIL reset_outputs_w2_w32: got sum32=%h sum2=%h expected 0", bus32.sum, bus2.sum);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int fd, nd, bn; logic [7:0] s; logic c; bit st;
    run8(8'h35, 8'h4A, 1'b0, 1'b0, 12, fd, nd, bn, s, c, st);
    checks++; if (fd != 8)  begin errors++; $display("FAIL basic_latency: got %0d expected 8", fd); end
    checks++; if (nd != 1)  begin errors++; $display("FAIL basic_done_count: got %0d expected 1", nd); end
    checks++; if (bn != 9)  begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 9", bn); end
    checks++; if ({c, s} !== 9'h07F) begin errors++; $display("FAIL basic_result: got cout=%b sum=%h expected cout=0 sum=7f", c, s); end
    checks++; if (!st) begin errors++; $display("FAIL basic_sum_held: got changed before done expected held %h", last8); end
    last8 = 8'h7F;
    repeat (3) @(negedge clk);
    checks++;
    if (bus8.sum !== 8'h7F || bus8.busy !== 1'b0) begin
      errors++; $display("FAIL idle_hold: got sum=%h busy=%b expected sum=7f busy=0", bus8.sum, bus8.busy);
    end
  endtask

  task automatic test_overflow;
    int fd, nd, bn; logic [7:0] s; logic c; bit st;
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 10, fd, nd, bn, s, c, st);
    checks++; if ({c, s} !== 9'h100 || fd != 8) begin errors++; $display("FAIL overflow_ff_01: got cout=%b sum=%h at %0d expected cout=1 sum=00 at 8", c, s, fd); end
    checks++; if (!st) begin errors++; $display("FAIL overflow_sum_held: got changed before done expected %h", last8); end
    last8 = 8'h00;
    run8(8'hFF, 8'h00, 1'b1, 1'b0, 10, fd, nd, bn, s, c, st);
    checks++; if ({c, s} !== 9'h100 || fd != 8) begin errors++; $display("FAIL overflow_ff_cin: got cout=%b sum=%h at %0d expected cout=1 sum=00 at 8", c, s, fd); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, nd; logic [8:0] r1, r2;
    d1 = -1; d2 = -1; nd = 0; r1 = '0; r2 = '0;
    bus8.a = 8'h35; bus8.b = 8'h4A; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == W8 + 1) begin
        bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0; bus8.start = 1'b1;
      end
      if (k == W8 + 2) bus8.start = 1'b0;
      if (bus8.done === 1'b1) begin
        nd++;
        if (d1 < 0) begin d1 = k; r1 = {bus8.cout, bus8.sum}; end
        else if (d2 < 0) begin d2 = k; r2 = {bus8.cout, bus8.sum}; end
      end
      @(negedge clk);
    end
    checks++; if (nd != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", nd); end
    checks++; if (d1 != 8 || d2 - d1 != 10) begin errors++; $display("FAIL b2b_spacing: got first=%0d gap=%0d expected first=8 gap=10", d1, d2 - d1); end
    checks++; if (r1 !== 9'h07F) begin errors++; $display("FAIL b2b_first_result: got %h expected 07f", r1); end
    checks++; if (r2 !== 9'h100) begin errors++; $display("FAIL b2b_second_result: got %h expected 100", r2); end
    last8 = 8'h00;
  endtask

  task automatic test_hold_start;
    int fd, nd, bn; logic [7:0] s; logic c; bit st; logic [63:0] r;
    r = ref_add(64'h5A, 64'h33, 1'b1);
    run8(8'h5A, 8'h33, 1'b1, 1'b1, 2 * W8 + 4, fd, nd, bn, s, c, st);
    checks++; if ({c, s} !== r[8:0]) begin errors++; $display("FAIL hold_result: got %h expected %h", {c, s}, r[8:0]); end
    checks++; if (nd != 1) begin errors++; $display("FAIL hold_done_count: got %0d expected 1", nd); end
    checks++; if (bn != 9) begin errors++; $display("FAIL hold_busy_cycles: got %0d expected 9", bn); end
    last8 = r[7:0];
  endtask

  task automatic test_reset_abort;
    int nd;
    nd = 0;
    bus8.a = 8'h35; bus8.b = 8'h4A; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'h0) begin
      errors++; $display("FAIL abort_clear: got busy=%b done=%b cout=%b sum=%h expected all 0",
                         bus8.busy, bus8.done, bus8.cout, bus8.sum);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) nd++;
      @(negedge clk);
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", nd); end
    last8 = 8'h00;
  endtask

  task automatic test_after_reset;
    int fd, nd, bn; logic [7:0] s; logic c; bit st;
    run8(8'hC3, 8'h5E, 1'b1, 1'b0, 10, fd, nd, bn, s, c, st);
    checks++; if (fd != 8 || {c, s} !== 9'h122) begin errors++; $display("FAIL after_reset: got %h at %0d expected 122 at 8", {c, s}, fd); end
    last8 = 8'h22;
  endtask

  task automatic test_sweep_w8;
    int fd, nd, bn; logic [7:0] s, av, bv; logic c, cv; bit st; logic [63:0] r;
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom_range(1));
      if (i == 0) begin av = 8'hFF; bv = 8'hFF; cv = 1'b1; end
      r = ref_add(64'(av), 64'(bv), cv);
      run8(av, bv, cv, 1'b0, W8 + 2, fd, nd, bn, s, c, st);
      checks++;
      if (fd != 8 || nd != 1 || {c, s} !== r[8:0] || !st) begin
        errors++;
        $display("FAIL sweep8[%0d]: got %h at %0d (n=%0d held=%0d) expected %h at 8 for %h+%h+%b",
                 i, {c, s}, fd, nd, st, r[8:0], av, bv, cv);
      end
      last8 = r[7:0];
    end
  endtask

  task automatic test_sweep_w2;
    int fd; logic [1:0] s, av, bv; logic c, cv; logic [63:0] r;
    for (int i = 0; i < 200; i++) begin
      av = 2'($urandom); bv = 2'($urandom); cv = 1'($urandom_range(1));
      if (i == 0) begin av = 2'b11; bv = 2'b11; cv = 1'b1; end
      r = ref_add(64'(av), 64'(bv), cv);
      bus2.a = av; bus2.b = bv; bus2.cin = cv; bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0; fd = -1; s = '0; c = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (bus2.done === 1'b1 && fd < 0) begin fd = k; s = bus2.sum; c = bus2.cout; end
        @(negedge clk);
      end
      checks++;
      if (fd != 2 || {c, s} !== r[2:0]) begin
        errors++; $display("FAIL sweep2[%0d]: got %h at %0d expected %h at 2", i, {c, s}, fd, r[2:0]);
      end
    end
  endtask

  task automatic test_sweep_w32;
    int fd; logic [31:0] s, av, bv; logic c, cv; logic [63:0] r;
    for (int i = 0; i < 100; i++) begin
      av = $urandom; bv = $urandom; cv = 1'($urandom_range(1));
      if (i == 0) begin av = '1; bv = '1; cv = 1'b1; end
      if (i == 1) begin av = '1; bv = '0; cv = 1'b1; end
      r = ref_add(64'(av), 64'(bv), cv);
      bus32.a = av; bus32.b = bv; bus32.cin = cv; bus32.start = 1'b1;
      @(negedge clk);
      bus32.start = 1'b0; fd = -1; s = '0; c = 1'b0;
      for (int k = 0; k < 34; k++) begin
        if (bus32.done === 1'b1 && fd < 0) begin fd = k; s = bus32.sum; c = bus32.cout; end
        @(negedge clk);
      end
      checks++;
      if (fd != 32 || {c, s} !== r[32:0]) begin
        errors++; $display("FAIL sweep32[%0d]: got %h at %0d expected %h at 32", i, {c, s}, fd, r[32:0]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_back_to_back;
    test_hold_start;
    test_reset_abort;
    test_after_reset;
    test_sweep_w8;
    test_sweep_w2;
    test_sweep_w32;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_serial_ctrl.md
ADD_SERIAL_CTRL -- requirements
Module: add_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; sampled on the edge that accepts start.
REQ-006 b  input  WIDTH  operand B; sampled on the edge that accepts start.
REQ-007 cin  input  1  carry-in; sampled on the edge that accepts start.
REQ-008 busy  output  1  high while an addition is in progress (RUN or DONE).
REQ-009 done  output  1  one-cycle pulse; sum and cout are valid while it is high.
REQ-010 sum  output  WIDTH  registered result, held until the next accepted start.
REQ-011 cout  output  1  registered carry-out, held like sum.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, using one full-adder instance once per cycle, LSB first.
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; busy SHALL be high in RUN and DONE.
REQ-014 IDLE: start=1 at an edge SHALL latch a, b and cin into shift/carry registers, clear the bit counter to 0, and go to RUN.
REQ-015 RUN: each edge SHALL feed operand bit[0] of A and B plus the carry register into the full adder, shift the sum bit into the result MSB, shift the operands right, store the carry-out and increment the counter.
REQ-016 RUN SHALL go to DONE on the edge that processes bit WIDTH-1, so that exactly WIDTH edges are spent in RUN.
REQ-017 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-018 Latency: if start is accepted at edge E0, done SHALL be high from edge E(WIDTH) to edge E(WIDTH+1).
REQ-019 sum and cout SHALL update only at the edge entering DONE.
REQ-020 sum and cout SHALL keep their values through IDLE and during the next addition until that addition's DONE.
REQ-021 start in RUN or DONE SHALL be ignored, with no queuing; operand changes after acceptance SHALL have no effect.
REQ-022 start high in the IDLE cycle that directly follows DONE SHALL be accepted, giving a back-to-back throughput of one result every WIDTH+2 cycles.
REQ-023 Overflow SHALL be reported only through cout; sum wraps modulo 2^WIDTH.
REQ-024 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap while in RUN.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE and clear busy, done, sum, cout, the counter and all shift/carry registers to 0, independent of clk.
REQ-026 Asserting rst mid-operation SHALL abort the addition; no done pulse SHALL follow it.
REQ-027 After rst is released, the first edge with start=1 SHALL be accepted normally.

Structure
REQ-028 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default SHALL live in a shared package/include add_pkg, used by this and any later serial-arithmetic controller.
REQ-029 The single sub-module SHALL be the existing add_full, instantiated once; no other arithmetic SHALL be inferred for the sum path.
REQ-030 The FSM, counter and shift registers SHALL be in this module; the expected implementation size is 120-250 lines.

Verification
REQ-031 The bench SHALL cover: WIDTH=8, a=0x35, b=0x4A, cin=0, start at E0 -> done only at E8..E9, sum=0x7F, cout=0.
REQ-032 The bench SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-033 The bench SHALL cover: start held high and operands changed to 0x11/0x22 during RUN -> the first result is unaffected, exactly one done occurs, and busy stays high for 9 cycles.
REQ-034 The bench SHALL cover: rst pulsed at E4 of an addition -> busy=0, sum=0 and cout=0 immediately, and no done for 12 following cycles.
REQ-035 The bench SHALL cover: start asserted in the IDLE cycle after done with a=0x80, b=0x80 -> the second done occurs 10 cycles after the first, with sum=0x00 and cout=1.
REQ-036 The bench SHALL cover a random sweep of 1000 operand/cin triples against a reference a+b+cin model, including WIDTH=2 and WIDTH=32 builds.
